// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC packet format, used by the router, the PE and
// the injection buffer.
//   pkt_width()  total packet width for a given payload/address width
//   dst_lsb()    LSB of the dst field
//   src_lsb()    LSB of the src field
//   pkt_field()  extract a field from a packet (packets up to PKT_MAX_WIDTH)
//   fifo_op_e    encoding of the per-cycle FIFO operation {push, pop}
// Packet layout, MSB first: {dst, src, payload}.
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int unsigned PKT_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int unsigned pkt_width(input int unsigned data_width,
                                              input int unsigned addr_width);
        return data_width + 2 * addr_width;
    endfunction

    function automatic int unsigned dst_lsb(input int unsigned data_width,
                                            input int unsigned addr_width);
        return data_width + addr_width;
    endfunction

    function automatic int unsigned src_lsb(input int unsigned data_width);
        return data_width;
    endfunction

    // Returns the field right-aligned and zero-extended; callers truncate.
    function automatic logic [PKT_MAX_WIDTH-1:0] pkt_field(
        input logic [PKT_MAX_WIDTH-1:0] pkt,
        input int unsigned              lsb,
        input int unsigned              width
    );
        logic [PKT_MAX_WIDTH-1:0] mask;
        if (width >= PKT_MAX_WIDTH)
            mask = '1;
        else
            mask = (PKT_MAX_WIDTH'(1) << width) - PKT_MAX_WIDTH'(1);
        return (pkt >> lsb) & mask;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// -----------------------------------------------------------------------------
// noc_sync_fifo
// Single-clock show-ahead FIFO. The head entry is presented combinationally
// from registered storage; there is no bypass from wr_data to rd_data.
// Parameters: WIDTH (entry bits), DEPTH (entries, power of two, >= 2).
// Ports:
//   clk      in   clock, all logic on posedge
//   rst      in   synchronous active-high reset (pointers and count only)
//   push     in   write wr_data this cycle (ignored when full)
//   wr_data  in   WIDTH  entry to write
//   pop      in   consume the head entry this cycle (ignored when empty)
//   rd_data  out  WIDTH  head entry, don't-care while !valid
//   valid    out  FIFO not empty
//   count    out  $clog2(DEPTH)+1  registered occupancy
//   full     out  count == DEPTH
// -----------------------------------------------------------------------------
module noc_sync_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    fifo_op_e         op;

    // Decisions use the count registered at the start of the cycle, so a push
    // into a full FIFO is refused even when a pop happens alongside it.
    assign full    = (count == CNT_W'(DEPTH));
    assign valid   = (count != '0);
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign op      = fifo_op_e'({do_push, do_pop});
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; entries are only observable after a push
    // has written them, and leaving the array unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs from the same instant of the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap on overflow.
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case (op)
                OP_PUSH: count <= count + CNT_W'(1);
                OP_POP:  count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pe_inject_buffer.sv
// -----------------------------------------------------------------------------
// pe_inject_buffer
// Decouples a PE (valid only, no backpressure) from the router's local input
// port (valid/ready). Packets are queued in a DEPTH-entry show-ahead FIFO;
// packets arriving while full are dropped and counted in a saturating counter.
// Build option: define SRC_STAMP_EN to overwrite the src field of every stored
// packet with LOCAL_ADDR; otherwise packets are stored bit-exact.
// Ports:
//   clk                  in   clock, all logic on posedge
//   rst                  in   synchronous active-high reset
//   i_valid_from_pe      in   packet present on i_data_from_pe
//   i_data_from_pe       in   packet {dst, src, payload}
//   i_ready_from_router  in   router accepts the head packet
//   o_valid_to_router    out  head packet valid
//   o_data_to_router     out  head packet
//   o_count              out  current occupancy
//   o_full               out  occupancy == DEPTH
//   o_drop_count         out  saturating count of dropped packets
// -----------------------------------------------------------------------------
module pe_inject_buffer
    import noc_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    ADDR_WIDTH     = 2,
    parameter int                    DEPTH          = 4,
    parameter logic [ADDR_WIDTH-1:0] LOCAL_ADDR     = '0,
    parameter int                    DROP_CNT_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_valid_from_pe,
    input  logic [DATA_WIDTH+2*ADDR_WIDTH-1:0]  i_data_from_pe,
    input  logic                                i_ready_from_router,
    output logic                                o_valid_to_router,
    output logic [DATA_WIDTH+2*ADDR_WIDTH-1:0]  o_data_to_router,
    output logic [$clog2(DEPTH):0]              o_count,
    output logic                                o_full,
    output logic [DROP_CNT_WIDTH-1:0]           o_drop_count
);

    localparam int PKT_W   = int'(pkt_width(DATA_WIDTH, ADDR_WIDTH));
    localparam int DST_LSB = int'(dst_lsb(DATA_WIDTH, ADDR_WIDTH));

`ifdef SRC_STAMP_EN
    localparam bit STAMP_EN = 1'b1;
`else
    localparam bit STAMP_EN = 1'b0;
`endif

    logic [ADDR_WIDTH-1:0] dst_field;
    logic [DATA_WIDTH-1:0] payload_field;
    logic [PKT_W-1:0]      stamped_pkt;
    logic [PKT_W-1:0]      wr_data;

    // Rebuild the packet with this node as source; dst and payload pass through.
    assign dst_field     = ADDR_WIDTH'(pkt_field(PKT_MAX_WIDTH'(i_data_from_pe),
                                                 DST_LSB, ADDR_WIDTH));
    assign payload_field = DATA_WIDTH'(pkt_field(PKT_MAX_WIDTH'(i_data_from_pe),
                                                 0, DATA_WIDTH));
    assign stamped_pkt   = {dst_field, LOCAL_ADDR, payload_field};
    assign wr_data       = STAMP_EN ? stamped_pkt : i_data_from_pe;

    noc_sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (i_valid_from_pe),
        .wr_data (wr_data),
        .pop     (i_ready_from_router),
        .rd_data (o_data_to_router),
        .valid   (o_valid_to_router),
        .count   (o_count),
        .full    (o_full)
    );

    // A drop is judged against the registered full flag, matching the FIFO's
    // own push refusal, so a same-cycle pop never rescues the packet.
    always_ff @(posedge clk) begin
        if (rst)
            o_drop_count <= '0;
        else if (i_valid_from_pe && o_full && (o_drop_count != '1))
            o_drop_count <= o_drop_count + DROP_CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_pe_inject_buffer.sv
// -----------------------------------------------------------------------------
// tb_pe_inject_buffer
// Self-checking bench for pe_inject_buffer at default parameters. Expected
// packets are queued when they are offered to the DUT and compared when the
// router side handshakes; status outputs are compared against explicit values.
// -----------------------------------------------------------------------------
module tb_pe_inject_buffer;

    localparam int              DW    = 16;
    localparam int              AW    = 2;
    localparam int              DEPTH = 4;
    localparam int              DCW   = 8;
    localparam logic [AW-1:0]   LOCAL = 2'd0;
    localparam int              PW    = DW + 2 * AW;

    logic          clk;
    logic          rst;
    logic          valid_in;
    logic [PW-1:0] data_in;
    logic          ready_in;
    logic          o_valid;
    logic [PW-1:0] o_data;
    logic [2:0]    o_count;
    logic          o_full;
    logic [DCW-1:0] o_drop;

    int            checks;
    int            errors;
    logic [PW-1:0] exp_q[$];
    int            model_cnt;
    int            model_drops;

    pe_inject_buffer #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .DEPTH          (DEPTH),
        .LOCAL_ADDR     (LOCAL),
        .DROP_CNT_WIDTH (DCW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_valid_from_pe     (valid_in),
        .i_data_from_pe      (data_in),
        .i_ready_from_router (ready_in),
        .o_valid_to_router   (o_valid),
        .o_data_to_router    (o_data),
        .o_count             (o_count),
        .o_full              (o_full),
        .o_drop_count        (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [PW-1:0] expect_pkt(input logic [PW-1:0] d);
        logic [PW-1:0] r;
        r = d;
`ifdef SRC_STAMP_EN
        r[DW+AW-1:DW] = LOCAL;
`endif
        return r;
    endfunction

    function automatic logic [PW-1:0] mk_pkt(input int i);
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] pay;
        dst = AW'(i);
        src = AW'(i + 1);
        pay = 16'hA000 + DW'(i * 37);
        return {dst, src, pay};
    endfunction

    // Router-side scoreboard: every accepted packet must be the oldest expected.
    always @(negedge clk) begin
        if (!rst && o_valid && ready_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_data: got packet %h, required no packet", o_data);
            end else begin
                logic [PW-1:0] exp_pkt;
                exp_pkt = exp_q.pop_front();
                if (o_data !== exp_pkt) begin
                    errors++;
                    $display("FAIL pop_data: got %h, required %h", o_data, exp_pkt);
                end
            end
        end
    end

    // Drives one cycle of stimulus, updates the reference model, and returns
    // 1 time unit after the clock edge that consumed the stimulus.
    task automatic drive(input logic v, input logic [PW-1:0] d, input logic r);
        int  start;
        bit  push_ok;
        bit  pop_ok;
        start   = model_cnt;
        push_ok = v && (start < DEPTH);
        pop_ok  = r && (start > 0);
        if (v && !push_ok && model_drops < 255)
            model_drops++;
        if (push_ok)
            exp_q.push_back(expect_pkt(d));
        model_cnt = start + int'(push_ok) - int'(pop_ok);
        valid_in = v;
        data_in  = d;
        ready_in = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v, input logic [PW-1:0] d, input logic r);
        rst      = 1'b1;
        valid_in = v;
        data_in  = d;
        ready_in = r;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        valid_in    = 1'b0;
        ready_in    = 1'b0;
        exp_q.delete();
        model_cnt   = 0;
        model_drops = 0;
    endtask

    task automatic test_reset;
        do_reset(1'b0, '0, 1'b0);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b, required 0", o_valid);
        end
        checks++;
        if (o_count !== 3'd0) begin
            errors++; $display("FAIL reset_count: got %0d, required 0", o_count);
        end
        checks++;
        if (o_drop !== 8'd0) begin
            errors++; $display("FAIL reset_drop: got %0d, required 0", o_drop);
        end
        checks++;
        if (o_full !== 1'b0) begin
            errors++; $display("FAIL reset_full: got %b, required 0", o_full);
        end
        drive(1'b0, '0, 1'b0);
        checks++;
        if ({o_valid, o_count} !== 4'b0_000) begin
            errors++; $display("FAIL idle_state: got valid %b count %0d, required 0/0", o_valid, o_count);
        end
    endtask

    task automatic test_single_push;
        drive(1'b1, 20'h31234, 1'b1);
        checks++;
        if (o_valid !== 1'b1) begin
            errors++; $display("FAIL single_valid: got %b, required 1", o_valid);
        end
        checks++;
        if (o_data !== expect_pkt(20'h31234)) begin
            errors++; $display("FAIL single_data: got %h, required %h", o_data, expect_pkt(20'h31234));
        end
        checks++;
        if (o_count !== 3'd1) begin
            errors++; $display("FAIL single_count: got %0d, required 1", o_count);
        end
        drive(1'b0, '0, 1'b1);
        checks++;
        if ({o_valid, o_count} !== 4'b0_000) begin
            errors++; $display("FAIL single_drain: got valid %b count %0d, required 0/0", o_valid, o_count);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL single_popped: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_fill_drop;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, mk_pkt(i), 1'b0);
            if (i == 3) begin
                checks++;
                if ({o_full, o_count} !== 4'b1_100) begin
                    errors++; $display("FAIL fill_full: got full %b count %0d, required 1/4", o_full, o_count);
                end
            end
        end
        checks++;
        if (o_drop !== 8'd2) begin
            errors++; $display("FAIL fill_drops: got %0d, required 2", o_drop);
        end
        checks++;
        if (o_data !== expect_pkt(mk_pkt(0))) begin
            errors++; $display("FAIL fill_stall_data: got %h, required %h", o_data, expect_pkt(mk_pkt(0)));
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            checks++;
            if (o_count !== 3'(3 - i)) begin
                errors++; $display("FAIL drain_count: got %0d, required %0d", o_count, 3 - i);
            end
        end
        checks++;
        if (o_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL drain_empty: got valid %b pending %0d, required 0/0", o_valid, exp_q.size());
        end
    endtask

    task automatic test_full_push_pop;
        for (int i = 0; i < 4; i++)
            drive(1'b1, mk_pkt(10 + i), 1'b0);
        drive(1'b1, mk_pkt(20), 1'b1);
        checks++;
        if ({o_full, o_count} !== 4'b0_011) begin
            errors++; $display("FAIL fullpp_count: got full %b count %0d, required 0/3", o_full, o_count);
        end
        checks++;
        if (o_drop !== 8'd3) begin
            errors++; $display("FAIL fullpp_drop: got %0d, required 3", o_drop);
        end
        for (int i = 0; i < 3; i++)
            drive(1'b0, '0, 1'b1);
        checks++;
        if (o_count !== 3'd0 || exp_q.size() != 0) begin
            errors++; $display("FAIL fullpp_drain: got count %0d pending %0d, required 0/0", o_count, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, mk_pkt(30), 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, mk_pkt(31 + i), 1'b1);
            checks++;
            if ({o_valid, o_full, o_count} !== 5'b1_0_001) begin
                errors++; $display("FAIL b2b_count: got valid %b full %b count %0d, required 1/0/1", o_valid, o_full, o_count);
            end
        end
        drive(1'b0, '0, 1'b1);
        checks++;
        if (o_count !== 3'd0 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_drain: got count %0d pending %0d, required 0/0", o_count, exp_q.size());
        end
        checks++;
        if (o_drop !== 8'd3) begin
            errors++; $display("FAIL b2b_drops: got %0d, required 3", o_drop);
        end
    endtask

    task automatic test_drop_saturate;
        for (int i = 0; i < 4; i++)
            drive(1'b1, mk_pkt(50 + i), 1'b0);
        for (int i = 0; i < 300; i++)
            drive(1'b1, mk_pkt(60 + i), 1'b0);
        checks++;
        if (o_drop !== 8'hFF) begin
            errors++; $display("FAIL drop_saturate: got %0d, required 255", o_drop);
        end
        for (int i = 0; i < 4; i++)
            drive(1'b0, '0, 1'b1);
        checks++;
        if (o_count !== 3'd0 || exp_q.size() != 0) begin
            errors++; $display("FAIL sat_drain: got count %0d pending %0d, required 0/0", o_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_drain;
        for (int i = 0; i < 4; i++)
            drive(1'b1, mk_pkt(70 + i), 1'b0);
        drive(1'b0, '0, 1'b1);
        checks++;
        if (o_count !== 3'd3) begin
            errors++; $display("FAIL mid_count: got %0d, required 3", o_count);
        end
        do_reset(1'b1, mk_pkt(80), 1'b1);
        checks++;
        if ({o_valid, o_full, o_count} !== 5'b0_0_000) begin
            errors++; $display("FAIL mid_reset_state: got valid %b full %b count %0d, required 0/0/0", o_valid, o_full, o_count);
        end
        checks++;
        if (o_drop !== 8'd0) begin
            errors++; $display("FAIL mid_reset_drop: got %0d, required 0", o_drop);
        end
        drive(1'b0, '0, 1'b0);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_idle: got valid %b, required 0", o_valid);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_cnt   = 0;
        model_drops = 0;
        rst         = 1'b1;
        valid_in    = 1'b0;
        data_in     = '0;
        ready_in    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_push();
        test_fill_drop();
        test_full_push_pop();
        test_back_to_back();
        test_drop_saturate();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_inject_buffer.md
# pe_inject_buffer

Injection buffer between a PE's outgoing packet stream and the router's local input port. It decouples the PE, which issues packets with a bare valid and no backpressure, from the router, which accepts packets only when it asserts ready. Packets are held in a DEPTH-entry show-ahead FIFO. Arrivals while full are dropped and counted.

## Interface
- DATA_WIDTH, 16, payload bits per packet
- ADDR_WIDTH, 2, width of each address field
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- LOCAL_ADDR, 0, this node's address (ADDR_WIDTH bits)
- DROP_CNT_WIDTH, 8, width of the drop counter
- clk  input  1  single clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- i_valid_from_pe  input  1  packet present on i_data_from_pe this cycle
- i_data_from_pe  input  DATA_WIDTH+2*ADDR_WIDTH  packet {dst, src, payload}
- i_ready_from_router  input  1  router accepts the head packet this cycle
- o_valid_to_router  output  1  head packet valid
- o_data_to_router  output  DATA_WIDTH+2*ADDR_WIDTH  head packet
- o_count  output  $clog2(DEPTH)+1  current occupancy
- o_full  output  1  occupancy == DEPTH
- o_drop_count  output  DROP_CNT_WIDTH  saturating count of dropped packets

## Operation
- Packet layout:
  - dst = [DATA_WIDTH+2*ADDR_WIDTH-1 : DATA_WIDTH+ADDR_WIDTH]
  - src = [DATA_WIDTH+ADDR_WIDTH-1 : DATA_WIDTH]
  - payload = [DATA_WIDTH-1 : 0]
- Push:
  - i_valid_from_pe && !o_full writes the packet at wr_ptr, then wr_ptr++.
- Pop:
  - o_valid_to_router && i_ready_from_router, then rd_ptr++.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy is a registered count, updated by +1 (push only), −1 (pop only) or 0 (both or neither).
- Full/drop decisions use the registered count from the start of the cycle:
  - i_valid_from_pe while o_full drops the packet, even if a pop happens the same cycle.
  - A drop increments o_drop_count, which saturates at all-ones and never wraps.
- Simultaneous push and pop with 0 < count < DEPTH: both take effect and the count is unchanged.
- No bypass path. A push into an empty FIFO is not visible on the output in the same cycle.
- o_valid_to_router = (count != 0).
- o_data_to_router = mem[rd_ptr], read combinationally from registered storage.
- Storage is not reset. o_data_to_router is don't-care while o_valid_to_router = 0.
- o_data_to_router and o_valid_to_router hold stable while stalled (valid && !ready).
- Router handshake rule: once o_valid_to_router rises, it does not fall until the packet is popped.

## Timing
- Reset: when rst = 1 at a clock edge:
  - pointers, count and o_drop_count go to 0
  - o_valid_to_router = 0, o_full = 0, o_count = 0
  - any in-flight packets are discarded
- rst overrides push and pop in the same cycle.
- Latency: a push at edge N gives o_valid_to_router = 1 with that packet during cycle N+1, when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- o_full and o_count change only at clock edges.

## Configuration
- SRC_STAMP_EN defined:
  - the src field of every written packet is replaced by LOCAL_ADDR
  - dst and payload are stored unchanged
- SRC_STAMP_EN undefined: packets are stored bit-exact as received.

## Structure
- Shared package noc_pkg holds:
  - localparam functions for PKT_WIDTH = DATA_WIDTH+2*ADDR_WIDTH
  - field offsets DST_LSB and SRC_LSB
  - a packet-field extract helper, shared with the router and PE
- One sub-module, noc_sync_fifo, contains storage, pointers and count. It takes parameters WIDTH and DEPTH.
- The top level adds:
  - the drop counter
  - source stamping
  - port mapping

## Test plan
- Reset, then idle: o_valid_to_router = 0, o_count = 0, o_drop_count = 0.
- Push 0x3_1234 with router ready = 1:
  - o_valid_to_router = 1 the next cycle
  - data equals the input (or the src field = LOCAL_ADDR with SRC_STAMP_EN)
  - popped that cycle, count returns to 0
- Ready held 0, push 6 packets at DEPTH = 4:
  - o_full = 1 after 4 pushes
  - o_drop_count = 2
  - raise ready: the 4 packets drain in order, one per cycle
- Full FIFO with simultaneous push and pop: push is dropped (o_drop_count +1), count goes 4→3.
- Continuous push and pop for 16 cycles, ready = 1:
  - output order matches input
  - pointers wrap, count stays at 1, no drops
- Assert rst mid-drain with count = 3: next cycle count = 0, o_valid_to_router = 0, o_drop_count = 0.
